// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one block-wide data memory between the data cache (port 0) and the
//   instruction cache (port 1). Each cache sees a private memory-style port
//   with the same read/write/busywait handshake the memory uses. Transactions
//   are serialized and separated by one RECOVER cycle so the memory always
//   sees its strobes fall between transactions.
//
//   Handshake (all three ports): a requester raises read and/or write
//   (its "valid") and holds strobe, address and writedata stable until it
//   samples busywait low on a clock edge (busywait low is its "ready"). Read
//   data is only meaningful in the cycle busywait is low. Read plus write on
//   one port is treated as a write.
//
//   Ports:
//     clock, reset                        clock, synchronous active-high reset
//     p0_* / p1_*                         dcache / icache request ports
//       read, write, address, writedata   requester inputs
//       readdata, busywait                arbiter outputs (readdata broadcast)
//     mem_read, mem_write, mem_address,
//     mem_writedata                       memory request outputs
//     mem_readdata, mem_busywait          memory responses
//     grant                               one-hot owner, 00 when none
//     debug_state                         FSM state (0 IDLE, 1 GNT0, 2 GNT1,
//                                         3 RECOVER)
//
//   Build option: ARB_ROUND_ROBIN_EN selects round-robin arbitration between
//   simultaneous requests; undefined gives fixed priority to port 0.
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [DATA_W-1:0] p0_writedata,
  output logic [DATA_W-1:0] p0_readdata,
  output logic              p0_busywait,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [DATA_W-1:0] p1_writedata,
  output logic [DATA_W-1:0] p1_readdata,
  output logic              p1_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait,
  output logic [1:0]        grant,
  output logic [1:0]        debug_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT0    = 2'd1,
    GNT1    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t state, state_next;
  logic   seen_busy;    // memory has raised busywait during this grant
  logic   done_port;    // port whose transaction just completed (for RECOVER)
  logic   after_reset;  // first cycle after reset: busywaits held low
  logic   p0_req, p1_req;
  logic   granted;
  logic   complete;
`ifdef ARB_ROUND_ROBIN_EN
  logic   last_served;
`endif

  assign p0_req   = p0_read | p0_write;
  assign p1_req   = p1_read | p1_write;
  assign granted  = (state == GNT0) || (state == GNT1);
  // A low busywait only counts as completion once the memory has been seen
  // busy, so a memory that registers its busywait cannot fake a 0-cycle read.
  assign complete = granted && seen_busy && !mem_busywait;

  assign p0_readdata = mem_readdata;
  assign p1_readdata = mem_readdata;
  assign debug_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      seen_busy   <= 1'b0;
      done_port   <= 1'b0;
      after_reset <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      last_served <= 1'b1;
`endif
    end else begin
      state       <= state_next;
      after_reset <= 1'b0;
      if (!granted || complete) begin
        seen_busy <= 1'b0;
      end else if (mem_busywait) begin
        seen_busy <= 1'b1;
      end
      if (complete) begin
        done_port <= (state == GNT1);
`ifdef ARB_ROUND_ROBIN_EN
        last_served <= (state == GNT1);
`endif
      end
    end
  end

  always_comb begin
    state_next    = state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    grant         = 2'b00;
    p0_busywait   = p0_req;
    p1_busywait   = p1_req;

    case (state)
      IDLE: begin
        if (!after_reset) begin
          if (p0_req && p1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            state_next = last_served ? GNT0 : GNT1;
`else
            state_next = GNT0;
`endif
          end else if (p0_req) begin
            state_next = GNT0;
          end else if (p1_req) begin
            state_next = GNT1;
          end
        end
      end
      GNT0: begin
        mem_write     = p0_write;
        mem_read      = p0_read & ~p0_write;
        mem_address   = p0_address;
        mem_writedata = p0_writedata;
        grant         = 2'b01;
        if (complete) begin
          p0_busywait = 1'b0;
          state_next  = RECOVER;
        end
      end
      GNT1: begin
        mem_write     = p1_write;
        mem_read      = p1_read & ~p1_write;
        mem_address   = p1_address;
        mem_writedata = p1_writedata;
        grant         = 2'b10;
        if (complete) begin
          p1_busywait = 1'b0;
          state_next  = RECOVER;
        end
      end
      RECOVER: begin
        // The port just served still holds its strobes here; keep it
        // released so it can move on, and ignore those strobes.
        state_next = IDLE;
        if (done_port) begin
          p1_busywait = 1'b0;
        end else begin
          p0_busywait = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    // Reset drops everything in the same cycle, mid-transaction included.
    if (reset) begin
      state_next    = IDLE;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = '0;
      mem_writedata = '0;
      grant         = 2'b00;
    end
    if (reset || after_reset) begin
      p0_busywait = 1'b0;
      p1_busywait = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Bench for mem_arbiter: a behavioural block memory with configurable
//   latency, per-port request drivers, expected-readdata queues per port and a
//   served-order log for arbitration checks. Prints one summary line.
module tb_mem_arbiter;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

`ifdef ARB_ROUND_ROBIN_EN
  localparam int SIM_GAP = 0;  // re-request immediately: every IDLE is a conflict
`else
  localparam int SIM_GAP = 2;  // re-request after the IDLE cycle
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic [1:0]        p_read  = 2'b00;
  logic [1:0]        p_write = 2'b00;
  logic [ADDR_W-1:0] p_addr  [2];
  logic [DATA_W-1:0] p_wdata [2];
  logic [DATA_W-1:0] p_rdata [2];
  logic [1:0]        p_busy;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata, mem_readdata;
  logic              mem_busywait;
  logic [1:0]        grant;
  logic [1:0]        debug_state;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .p0_read       (p_read[0]),
    .p0_write      (p_write[0]),
    .p0_address    (p_addr[0]),
    .p0_writedata  (p_wdata[0]),
    .p0_readdata   (p_rdata[0]),
    .p0_busywait   (p_busy[0]),
    .p1_read       (p_read[1]),
    .p1_write      (p_write[1]),
    .p1_address    (p_addr[1]),
    .p1_writedata  (p_wdata[1]),
    .p1_readdata   (p_rdata[1]),
    .p1_busywait   (p_busy[1]),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait),
    .grant         (grant),
    .debug_state   (debug_state)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q0[$];
  logic [DATA_W-1:0] exp_q1[$];
  logic [DATA_W-1:0] model_mem [64];
  int served[$];
  logic log_en = 1'b0;

  function automatic logic [DATA_W-1:0] init_word(input int i);
    if (i == 5) return 32'hDEADBEEF;
    return 32'hC0DE0000 + i;
  endfunction

  // ---------------- behavioural memory ----------------
  // mode 0: busywait high for mem_lat cycles from the first strobed cycle.
  // mode 1: busywait low in the first strobed cycle, then high for 3 cycles.
  logic [DATA_W-1:0] mem_array [64];
  logic mem_init = 1'b1;
  int   mem_cnt  = 0;
  int   mem_lat  = 2;
  int   mem_mode = 0;

  assign mem_readdata = mem_array[mem_address];
  assign mem_busywait = (mem_read || mem_write) &&
                        ((mem_mode == 0) ? (mem_cnt < mem_lat)
                                         : (mem_cnt >= 1 && mem_cnt <= 3));

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem_array[i] <= init_word(i);
      mem_cnt <= 0;
    end else if (mem_read || mem_write) begin
      if (mem_write && !mem_busywait) mem_array[mem_address] <= mem_writedata;
      mem_cnt <= mem_cnt + 1;
    end else begin
      mem_cnt <= 0;
    end
  end

  // served-order log: a completion is the owner's busywait low under grant
  always @(negedge clock) begin
    if (log_en) begin
      if (grant == 2'b01 && !p_busy[0] && (p_read[0] || p_write[0])) served.push_back(0);
      if (grant == 2'b10 && !p_busy[1] && (p_read[1] || p_write[1])) served.push_back(1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Issue one request on a port and wait for its completion. Afterwards the
  // port either keeps its strobes up for an immediate next request (gap 0)
  // or drops them for 'gap' edges.
  task automatic run_txn(input logic port, input logic rd, input logic wr,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input int gap);
    logic [DATA_W-1:0] exp_word;
    logic [1:0] own;
    int k;
    bit done;
    own = (port == 1'b0) ? 2'b01 : 2'b10;
    p_read[port]  = rd;
    p_write[port] = wr;
    p_addr[port]  = a;
    p_wdata[port] = d;
    if (wr) model_mem[a] = d;
    else if (port == 1'b0) exp_q0.push_back(model_mem[a]);
    else exp_q1.push_back(model_mem[a]);
    k = 0;
    done = 0;
    while (!done && k < 100) begin
      @(negedge clock);
      k++;
      if (!p_busy[port]) done = 1;
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL txn_timeout port=%0d got=busy required=done", port);
    end else begin
      n_vec++;
      if (grant !== own) begin
        n_err++;
        $display("FAIL early_release port=%0d grant got=%b required=%b", port, grant, own);
      end
      if (!wr) begin
        exp_word = (port == 1'b0) ? exp_q0.pop_front() : exp_q1.pop_front();
        n_vec++;
        if (p_rdata[port] !== exp_word) begin
          n_err++;
          $display("FAIL readdata port=%0d addr=%h got=%h required=%h", port, a, p_rdata[port], exp_word);
        end
      end
    end
    @(posedge clock);
    #1;
    if (gap > 0) begin
      p_read[port]  = 1'b0;
      p_write[port] = 1'b0;
    end
    repeat ((gap > 0) ? gap : 1) @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    p_read = 2'b11;
    p_addr[0] = 6'h0A;
    p_addr[1] = 6'h0B;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rst_mem_read got=%b required=0", mem_read); end
    n_vec++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL rst_mem_write got=%b required=0", mem_write); end
    n_vec++; if (grant !== 2'b00) begin n_err++; $display("FAIL rst_grant got=%b required=00", grant); end
    n_vec++; if (p_busy !== 2'b00) begin n_err++; $display("FAIL rst_busywait got=%b required=00", p_busy); end
    n_vec++; if (mem_address !== 6'h00) begin n_err++; $display("FAIL rst_mem_address got=%h required=00", mem_address); end
    n_vec++; if (mem_writedata !== 32'h0) begin n_err++; $display("FAIL rst_mem_writedata got=%h required=0", mem_writedata); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    mem_init = 1'b0;
    @(negedge clock);
    n_vec++; if (debug_state !== 2'd0) begin n_err++; $display("FAIL post_rst_state got=%0d required=0", debug_state); end
    n_vec++; if (grant !== 2'b00) begin n_err++; $display("FAIL post_rst_grant got=%b required=00", grant); end
    n_vec++; if (p_busy !== 2'b00) begin n_err++; $display("FAIL post_rst_busywait got=%b required=00", p_busy); end
    @(posedge clock);
    #1;
    p_read = 2'b00;
    idle(2);
  endtask

  task automatic test_read_latency();
    int gcnt = 0;
    int k = 0;
    bit done = 0;
    logic [DATA_W-1:0] exp_word;
    mem_lat = 5;
    exp_q0.push_back(model_mem[6'h05]);
    p_read[0] = 1'b1;
    p_write[0] = 1'b0;
    p_addr[0] = 6'h05;
    while (!done && k < 50) begin
      @(negedge clock);
      k++;
      if (grant == 2'b01) gcnt++;
      if (!p_busy[0]) done = 1;
    end
    n_vec++; if (!done) begin n_err++; $display("FAIL lat_timeout got=busy required=done"); end
    n_vec++; if (gcnt != 6) begin n_err++; $display("FAIL lat_grant_cycles got=%0d required=6", gcnt); end
    exp_word = exp_q0.pop_front();
    n_vec++; if (p_rdata[0] !== exp_word) begin n_err++; $display("FAIL lat_readdata got=%h required=%h", p_rdata[0], exp_word); end
    @(posedge clock);
    #1;
    p_read[0] = 1'b0;
    @(negedge clock);
    n_vec++; if (debug_state !== 2'd3) begin n_err++; $display("FAIL lat_recover_state got=%0d required=3", debug_state); end
    n_vec++; if (mem_read !== 1'b0 || grant !== 2'b00) begin n_err++; $display("FAIL lat_recover_strobe got=%b/%b required=0/00", mem_read, grant); end
    idle(2);
    mem_lat = 2;
  endtask

  task automatic test_write_p0();
    int k = 0;
    bit done = 0;
    bit seen = 0;
    bit p1_bad = 0;
    p_write[0] = 1'b1;
    p_read[0] = 1'b0;
    p_addr[0] = 6'h3F;
    p_wdata[0] = 32'h12345678;
    model_mem[6'h3F] = 32'h12345678;
    while (!done && k < 50) begin
      @(negedge clock);
      k++;
      if (p_busy[1] !== 1'b0) p1_bad = 1;
      if (grant == 2'b01 && !seen) begin
        seen = 1;
        n_vec++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin n_err++; $display("FAIL wr_strobes got=w%b r%b required=w1 r0", mem_write, mem_read); end
        n_vec++; if (mem_address !== 6'h3F) begin n_err++; $display("FAIL wr_address got=%h required=3f", mem_address); end
        n_vec++; if (mem_writedata !== 32'h12345678) begin n_err++; $display("FAIL wr_data got=%h required=12345678", mem_writedata); end
      end
      if (!p_busy[0]) done = 1;
    end
    n_vec++; if (!done || !seen) begin n_err++; $display("FAIL wr_timeout done=%b granted=%b required=1/1", done, seen); end
    n_vec++; if (p1_bad) begin n_err++; $display("FAIL wr_p1_busywait got=1 required=0"); end
    @(posedge clock);
    #1;
    p_write[0] = 1'b0;
    idle(2);
    run_txn(1'b0, 1'b1, 1'b0, 6'h3F, 32'h0, 2);
  endtask

  task automatic test_simultaneous();
    int exp_order[$];
    exp_order = '{0, 1, 0, 1};
    served.delete();
    log_en = 1'b1;
    fork
      begin
        run_txn(1'b0, 1'b1, 1'b0, 6'h01, 32'h0, SIM_GAP);
        run_txn(1'b0, 1'b1, 1'b0, 6'h01, 32'h0, 2);
      end
      begin
        run_txn(1'b1, 1'b1, 1'b0, 6'h02, 32'h0, SIM_GAP);
        run_txn(1'b1, 1'b1, 1'b0, 6'h02, 32'h0, 2);
      end
    join
    log_en = 1'b0;
    n_vec++;
    if (served.size() != exp_order.size()) begin
      n_err++;
      $display("FAIL sim_order_len got=%0d required=%0d", served.size(), exp_order.size());
    end else begin
      for (int i = 0; i < exp_order.size(); i++) begin
        n_vec++;
        if (served[i] != exp_order[i]) begin
          n_err++;
          $display("FAIL sim_order[%0d] got=p%0d required=p%0d", i, served[i], exp_order[i]);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_delayed_busy();
    int gcnt = 0;
    int k = 0;
    bit done = 0;
    logic [DATA_W-1:0] exp_word;
    mem_mode = 1;
    exp_q0.push_back(model_mem[6'h07]);
    p_read[0] = 1'b1;
    p_write[0] = 1'b0;
    p_addr[0] = 6'h07;
    while (!done && k < 50) begin
      @(negedge clock);
      k++;
      if (grant == 2'b01) begin
        gcnt++;
        if (gcnt == 1) begin
          n_vec++;
          if (p_busy[0] !== 1'b1) begin n_err++; $display("FAIL dly_first_cycle busywait got=%b required=1", p_busy[0]); end
        end
      end
      if (!p_busy[0]) done = 1;
    end
    n_vec++; if (!done) begin n_err++; $display("FAIL dly_timeout got=busy required=done"); end
    n_vec++; if (gcnt != 5) begin n_err++; $display("FAIL dly_completion_cycle got=%0d required=5", gcnt); end
    exp_word = exp_q0.pop_front();
    n_vec++; if (p_rdata[0] !== exp_word) begin n_err++; $display("FAIL dly_readdata got=%h required=%h", p_rdata[0], exp_word); end
    @(posedge clock);
    #1;
    p_read[0] = 1'b0;
    mem_mode = 0;
    idle(2);
  endtask

  task automatic test_reset_mid_grant();
    int k = 0;
    bit found = 0;
    bit done = 0;
    logic [DATA_W-1:0] exp_word;
    mem_lat = 4;
    exp_q1.push_back(model_mem[6'h02]);
    p_read[1] = 1'b1;
    p_write[1] = 1'b0;
    p_addr[1] = 6'h02;
    while (!found && k < 20) begin
      @(negedge clock);
      k++;
      if (grant == 2'b10) found = 1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL rmid_first_grant got=none required=10"); end
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rmid_mem_read got=%b required=0", mem_read); end
    n_vec++; if (grant !== 2'b00) begin n_err++; $display("FAIL rmid_grant got=%b required=00", grant); end
    n_vec++; if (p_busy !== 2'b00) begin n_err++; $display("FAIL rmid_busywait got=%b required=00", p_busy); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    n_vec++; if (debug_state !== 2'd0) begin n_err++; $display("FAIL rmid_state got=%0d required=0", debug_state); end
    n_vec++; if (grant !== 2'b00 || p_busy !== 2'b00) begin n_err++; $display("FAIL rmid_post grant/busy got=%b/%b required=00/00", grant, p_busy); end
    k = 0;
    found = 0;
    while (!found && k < 20) begin
      @(negedge clock);
      k++;
      if (grant == 2'b10) found = 1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL rmid_regrant got=none required=10"); end
    k = 0;
    while (!done && k < 50) begin
      @(negedge clock);
      k++;
      if (!p_busy[1]) done = 1;
    end
    n_vec++; if (!done || grant !== 2'b10) begin n_err++; $display("FAIL rmid_complete done=%b grant=%b required=1/10", done, grant); end
    exp_word = exp_q1.pop_front();
    n_vec++; if (p_rdata[1] !== exp_word) begin n_err++; $display("FAIL rmid_readdata got=%h required=%h", p_rdata[1], exp_word); end
    @(posedge clock);
    #1;
    p_read[1] = 1'b0;
    mem_lat = 2;
    idle(2);
  endtask

  task automatic test_rw_both();
    int k = 0;
    int gcnt = 0;
    bit done = 0;
    bit bad_rd = 0;
    bit bad_wr = 0;
    p_read[0] = 1'b1;
    p_write[0] = 1'b1;
    p_addr[0] = 6'h10;
    p_wdata[0] = 32'hA5A55A5A;
    model_mem[6'h10] = 32'hA5A55A5A;
    while (!done && k < 50) begin
      @(negedge clock);
      k++;
      if (grant == 2'b01) begin
        gcnt++;
        if (mem_read !== 1'b0) bad_rd = 1;
        if (mem_write !== 1'b1) bad_wr = 1;
      end
      if (!p_busy[0]) done = 1;
    end
    n_vec++; if (!done || gcnt == 0) begin n_err++; $display("FAIL rw_timeout done=%b grant_cycles=%0d required=1/>0", done, gcnt); end
    n_vec++; if (bad_rd) begin n_err++; $display("FAIL rw_mem_read got=1 required=0"); end
    n_vec++; if (bad_wr) begin n_err++; $display("FAIL rw_mem_write got=0 required=1"); end
    @(posedge clock);
    #1;
    p_read[0] = 1'b0;
    p_write[0] = 1'b0;
    idle(2);
    run_txn(1'b0, 1'b1, 1'b0, 6'h10, 32'h0, 2);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 64; i++) model_mem[i] = init_word(i);
    for (int i = 0; i < 2; i++) begin
      p_addr[i]  = '0;
      p_wdata[i] = '0;
    end
    test_reset();
    test_read_latency();
    test_write_p0();
    test_simultaneous();
    test_delayed_busy();
    test_reset_mid_grant();
    test_rw_both();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
